mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the pipeline's IF stage (instruction fetch) and MEM stage (load/store).
- Sequences one outstanding bus transaction at a time and drives if_stall/dm_stall into the pipeline control.
- Data requests take priority, with a starvation guard for fetch, fetch-cancel on branch flush, and a bus timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte strobes are DATA_W/8 bits)
STARVE_LIMIT, 4, max consecutive DM grants while if_req is pending
TIMEOUT, 64, cycles in a WAIT state without mem_rvalid before a bus error

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request, level, held until if_valid
if_addr  in  ADDR_W  fetch address
flush  in  1  cancel the current/pending fetch (branch taken)
if_valid  out  1  fetch complete, 1-cycle pulse
if_rdata  out  DATA_W  instruction (mem_rdata pass-through)
if_stall  out  1  if_req & ~if_valid
dm_req  in  1  data request, level, held until dm_valid
dm_we  in  1  1 = store
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_wstrb  in  DATA_W/8  store byte enables
dm_valid  out  1  data complete, 1-cycle pulse
dm_rdata  out  DATA_W  load data (mem_rdata pass-through)
dm_stall  out  1  dm_req & ~dm_valid
mem_req  out  1  bus request, held until mem_gnt
mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  registered bus command
mem_gnt  in  1  bus accepted command this cycle
mem_rvalid  in  1  response/ack (reads and writes)
mem_rdata  in  DATA_W  read data
bus_err  out  1  timeout pulse

Behaviour:
- Reset (rst=0, async): state IDLE; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; mem_wstrb=0; streak=0; discard=0; tcnt=0. if_valid=dm_valid=bus_err=0.
- States: IDLE, REQ_IF, REQ_DM, WAIT_IF, WAIT_DM.
- IDLE arbitration:
  - flush=1 blocks the IF grant this cycle.
  - DM wins if dm_req & (~if_req | streak<STARVE_LIMIT); otherwise IF wins if if_req.
  - On a grant, latch the command into the mem_* registers and go to REQ_x.
  - IF reads: mem_we=0, mem_wstrb=0.
- streak: +1 on a DM grant while if_req=1 (saturating); cleared on an IF grant, and on a DM grant with if_req=0.
- REQ_x: mem_req=1, command stable. On mem_gnt, go to WAIT_x and clear tcnt. mem_req is never withdrawn before mem_gnt.
- WAIT_x: mem_req=0.
  - On mem_rvalid: x_valid=1 (combinational), x_rdata=mem_rdata; go to IDLE.
  - Otherwise tcnt+1. When tcnt reaches TIMEOUT-1 without rvalid: x_valid=1, x_rdata=0, bus_err=1; go to IDLE.
- Minimum latency (gnt tied 1, rvalid the cycle after gnt): request seen in cycle 0, mem_req in cycle 1, x_valid in cycle 2.
- Flush:
  - flush in REQ_IF or WAIT_IF sets discard. The bus transaction still completes, but if_valid is suppressed.
  - The timeout path is also suppressed under discard, but bus_err still pulses.
  - discard clears on the return to IDLE.
  - flush in any other state has no effect; flush never affects DM.
- mem_rvalid outside WAIT states is ignored.
- Simultaneous if_req & dm_req in IDLE with streak<STARVE_LIMIT: DM granted; if_stall stays 1.
- Requesters change req/addr only on the cycle after their valid pulse. IDLE therefore never re-grants a completed request.

Test Plan:
- IF-only read, gnt=1, rvalid 1 cycle after gnt, if_addr=0x100, mem_rdata=0x00500093 -> mem_req in cycle 1 with addr 0x100, if_valid and if_rdata=0x00500093 in cycle 2, if_stall high in cycles 0-1.
- Store, dm_we=1, addr=0x2000, wdata=0xDEADBEEF, wstrb=0xF, gnt delayed 3 cycles -> mem_req held 4 cycles with a stable command, dm_valid on the rvalid cycle.
- if_req and dm_req held continuously, STARVE_LIMIT=4 -> grant order DM,DM,DM,DM,IF,DM...; streak resets after the IF grant.
- flush pulsed while in WAIT_IF, rvalid 2 cycles later -> no if_valid pulse, FSM back in IDLE; the next if_req (addr 0x200) is served normally.
- rvalid never arrives, TIMEOUT=64 -> at cycle 64 of WAIT_DM: dm_valid=1, dm_rdata=0, bus_err=1 for one cycle; a late rvalid is then ignored.
- rst driven low in WAIT_DM mid-transaction -> all outputs reset immediately without a clock; after release, a fresh if_req is served with the 3-cycle latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and load/store.
// One bus transaction in flight at a time; data side has priority with a fetch starvation guard.
//
// state   | meaning
// IDLE    | no transaction; arbitrate between fetch and data requests
// REQ_IF  | fetch command on the bus, mem_req held until mem_gnt
// REQ_DM  | data command on the bus, mem_req held until mem_gnt
// WAIT_IF | fetch accepted, waiting for mem_rvalid or timeout
// WAIT_DM | data accepted, waiting for mem_rvalid or timeout
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                flush,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic                dm_valid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err
);

  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int STRK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [TCNT_W-1:0] TC_LAST  = TCNT_W'(TIMEOUT - 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_IF  = 3'd1,
    REQ_DM  = 3'd2,
    WAIT_IF = 3'd3,
    WAIT_DM = 3'd4
  } state_t;

  state_t            state;
  logic [STRK_W-1:0] streak;
  logic [TCNT_W-1:0] tcnt;
  logic              discard;

  logic in_wait_if;
  logic in_wait_dm;
  logic tc_hit;
  logic wait_end;
  logic dm_win;
  logic if_win;

  assign in_wait_if = (state == WAIT_IF);
  assign in_wait_dm = (state == WAIT_DM);
  assign tc_hit     = (tcnt == TC_LAST);
  assign wait_end   = mem_rvalid | tc_hit;

  // A flush arriving on the completion cycle also drops that fetch.
  assign if_valid = in_wait_if & wait_end & ~discard & ~flush;
  assign dm_valid = in_wait_dm & wait_end;
  assign if_rdata = (in_wait_if & mem_rvalid) ? mem_rdata : '0;
  assign dm_rdata = (in_wait_dm & mem_rvalid) ? mem_rdata : '0;
  assign bus_err  = (in_wait_if | in_wait_dm) & ~mem_rvalid & tc_hit;
  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

  assign dm_win = dm_req & (~if_req | (streak < STRK_MAX));
  assign if_win = ~dm_win & if_req & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      streak    <= '0;
      discard   <= 1'b0;
      tcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (dm_win) begin
            state     <= REQ_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wstrb <= dm_wstrb;
            if (!if_req)
              streak <= '0;
            else if (streak != STRK_MAX)
              streak <= streak + STRK_W'(1);
          end else if (if_win) begin
            state     <= REQ_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            streak    <= '0;
          end
        end
        REQ_IF: begin
          if (flush)
            discard <= 1'b1;
          if (mem_gnt) begin
            state   <= WAIT_IF;
            mem_req <= 1'b0;
            tcnt    <= '0;
          end
        end
        REQ_DM: begin
          if (mem_gnt) begin
            state   <= WAIT_DM;
            mem_req <= 1'b0;
            tcnt    <= '0;
          end
        end
        WAIT_IF, WAIT_DM: begin
          if (in_wait_if && flush)
            discard <= 1'b1;
          if (wait_end) begin
            state   <= IDLE;
            discard <= 1'b0;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// sequences for flush, timeout and asynchronous reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, flush, dm_req, dm_we, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_wstrb;
  logic        if_valid, if_stall, dm_valid, dm_stall, mem_req, mem_we, bus_err;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .bus_err(bus_err)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_if_valid;
    logic [31:0] e_if_rdata;
    logic        e_if_stall;
    logic        e_dm_valid;
    logic [31:0] e_dm_rdata;
    logic        e_dm_stall;
    logic        e_mem_req;
    logic        chk_cmd;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic vin(input bit ifr, input logic [31:0] ia, input bit dr, input bit we,
                     input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws,
                     input bit g, input bit rv, input logic [31:0] rd);
    cur.if_req = ifr; cur.if_addr = ia; cur.dm_req = dr; cur.dm_we = we;
    cur.dm_addr = da; cur.dm_wdata = wd; cur.dm_wstrb = ws;
    cur.gnt = g; cur.rvalid = rv; cur.rdata = rd;
  endtask

  task automatic vexp(input bit ifv, input logic [31:0] ird, input bit ifs,
                      input bit dmv, input logic [31:0] drd, input bit dms,
                      input bit mreq, input bit cc, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] ws);
    cur.e_if_valid = ifv; cur.e_if_rdata = ird; cur.e_if_stall = ifs;
    cur.e_dm_valid = dmv; cur.e_dm_rdata = drd; cur.e_dm_stall = dms;
    cur.e_mem_req = mreq; cur.chk_cmd = cc; cur.e_we = we; cur.e_addr = a;
    cur.e_wdata = wd; cur.e_wstrb = ws;
    vecs.push_back(cur);
  endtask

  // Both requesters held; one 3-cycle transaction (IDLE, REQ, WAIT) for the chosen side.
  task automatic add_txn(input bit is_dm);
    vin(1, 32'h300, 1, 0, 32'h4000, 32'h0, 4'h0, 1, 1, 32'hA5A50000);
    vexp(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    if (is_dm) vexp(0, 0, 1, 0, 0, 1, 1, 1, 0, 32'h4000, 0, 0);
    else       vexp(0, 0, 1, 0, 0, 1, 1, 1, 0, 32'h300, 0, 0);
    if (is_dm) vexp(0, 0, 1, 1, 32'hA5A50000, 0, 0, 0, 0, 0, 0, 0);
    else       vexp(1, 32'hA5A50000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs;
    if_req = 0; if_addr = 0; flush = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
    dm_wdata = 0; dm_wstrb = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  initial begin
    rst = 1'b0;
    zero_inputs();

    // IF-only read, minimum latency
    vin(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);           vexp(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vin(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);           vexp(0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h100, 0, 0);
    vin(1, 32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h00500093); vexp(1, 32'h00500093, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                  vexp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // store with grant delayed 3 cycles
    vin(0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 0, 0); vexp(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      vin(0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      vexp(0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF);
    end
    vin(0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 1, 0, 0);  vexp(0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF);
    vin(0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 0, 0);  vexp(0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF);
    vin(0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 1, 32'h12345678);
    vexp(0, 0, 0, 1, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
    vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                  vexp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // starvation guard: DM x4, IF, then again to show the streak restarted
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) add_txn(1);
      add_txn(0);
    end
    vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                  vexp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    #2;
    chk("reset mem_req", mem_req, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset valids/bus_err", {if_valid, dm_valid, bus_err}, 0);
    #10 rst = 1'b1;
    next_cyc();

    foreach (vecs[i]) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr; flush = 1'b0;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we; dm_addr = vecs[i].dm_addr;
      dm_wdata = vecs[i].dm_wdata; dm_wstrb = vecs[i].dm_wstrb;
      mem_gnt = vecs[i].gnt; mem_rvalid = vecs[i].rvalid; mem_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d if_valid", i), if_valid, vecs[i].e_if_valid);
      chk($sformatf("v%0d if_stall", i), if_stall, vecs[i].e_if_stall);
      chk($sformatf("v%0d dm_valid", i), dm_valid, vecs[i].e_dm_valid);
      chk($sformatf("v%0d dm_stall", i), dm_stall, vecs[i].e_dm_stall);
      chk($sformatf("v%0d mem_req", i), mem_req, vecs[i].e_mem_req);
      chk($sformatf("v%0d bus_err", i), bus_err, 0);
      if (vecs[i].e_if_valid) chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].e_if_rdata);
      if (vecs[i].e_dm_valid) chk($sformatf("v%0d dm_rdata", i), dm_rdata, vecs[i].e_dm_rdata);
      if (vecs[i].chk_cmd) begin
        chk($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_we);
        chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
        chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
        chk($sformatf("v%0d mem_wstrb", i), mem_wstrb, vecs[i].e_wstrb);
      end
      next_cyc();
    end

    // flush in IDLE blocks the grant; flush in WAIT_IF discards the fetch
    zero_inputs();
    if_req = 1; if_addr = 32'h180; mem_gnt = 1; flush = 1;
    @(negedge clk); chk("flush idle mem_req", mem_req, 0);
    next_cyc(); flush = 0;
    @(negedge clk); chk("flush idle blocked", mem_req, 0);
    next_cyc();
    @(negedge clk); chk("fl req mem_req", mem_req, 1); chk("fl req addr", mem_addr, 32'h180);
    next_cyc(); flush = 1;
    @(negedge clk); chk("fl wait if_valid", if_valid, 0);
    next_cyc(); flush = 0; if_addr = 32'h200;
    @(negedge clk); chk("fl wait2 if_valid", if_valid, 0); chk("fl wait2 if_stall", if_stall, 1);
    next_cyc(); mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk); chk("fl discarded if_valid", if_valid, 0);
    next_cyc(); mem_rvalid = 0;
    @(negedge clk); chk("fl back idle mem_req", mem_req, 0); chk("fl idle if_valid", if_valid, 0);
    next_cyc();
    @(negedge clk); chk("fl next mem_req", mem_req, 1); chk("fl next addr", mem_addr, 32'h200);
    next_cyc(); mem_rvalid = 1; mem_rdata = 32'h11112222;
    @(negedge clk); chk("fl next if_valid", if_valid, 1); chk("fl next if_rdata", if_rdata, 32'h11112222);
    next_cyc(); zero_inputs();
    @(negedge clk); chk("fl done mem_req", mem_req, 0);
    next_cyc();

    // bus timeout on a load
    dm_req = 1; dm_addr = 32'h3000; mem_gnt = 1; mem_rdata = 32'hFFFFFFFF;
    next_cyc();
    @(negedge clk); chk("to req mem_req", mem_req, 1);
    next_cyc();
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      chk($sformatf("to wait%0d dm_valid", k), dm_valid, 0);
      chk($sformatf("to wait%0d bus_err", k), bus_err, 0);
      next_cyc();
    end
    @(negedge clk);
    chk("to dm_valid", dm_valid, 1); chk("to dm_rdata", dm_rdata, 0);
    chk("to bus_err", bus_err, 1); chk("to dm_stall", dm_stall, 0);
    next_cyc(); dm_req = 0; mem_rvalid = 1;
    @(negedge clk);
    chk("late rvalid dm_valid", dm_valid, 0); chk("late rvalid bus_err", bus_err, 0);
    chk("late rvalid mem_req", mem_req, 0);
    next_cyc(); mem_rvalid = 0;
    @(negedge clk); chk("late rvalid idle", {mem_req, dm_valid, if_valid}, 0);
    next_cyc();

    // asynchronous reset in WAIT_DM
    dm_req = 1; dm_we = 1; dm_addr = 32'h5000; dm_wdata = 32'hCAFEF00D; dm_wstrb = 4'h3; mem_gnt = 1;
    next_cyc();
    next_cyc(); mem_rvalid = 1; mem_rdata = 32'h77;
    #1;
    chk("pre-rst dm_valid", dm_valid, 1); chk("pre-rst mem_addr", mem_addr, 32'h5000);
    rst = 1'b0;
    #1;
    chk("rst dm_valid", dm_valid, 0); chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_we", mem_we, 0); chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_wstrb", mem_wstrb, 0); chk("rst mem_req", mem_req, 0);
    zero_inputs();
    next_cyc();
    @(negedge clk); rst = 1'b1;
    next_cyc();
    if_req = 1; if_addr = 32'h600; mem_gnt = 1;
    @(negedge clk); chk("post-rst c0 mem_req", mem_req, 0); chk("post-rst c0 if_stall", if_stall, 1);
    next_cyc();
    @(negedge clk); chk("post-rst c1 mem_req", mem_req, 1); chk("post-rst c1 addr", mem_addr, 32'h600);
    next_cyc(); mem_rvalid = 1; mem_rdata = 32'h0FF00FF0;
    @(negedge clk); chk("post-rst c2 if_valid", if_valid, 1); chk("post-rst c2 if_rdata", if_rdata, 32'h0FF00FF0);
    next_cyc(); zero_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
